// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one shift-amount bit resolved per stage.
module shift_unit_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);
  logic               advance;
  logic               v_q [SHAMT_W];
  logic               v_d [SHAMT_W];
  logic [WIDTH-1:0]   d_q [SHAMT_W];
  logic [WIDTH-1:0]   d_d [SHAMT_W];
  logic [SHAMT_W-1:0] s_q [SHAMT_W];
  logic [SHAMT_W-1:0] s_d [SHAMT_W];
  logic [1:0]         m_q [SHAMT_W];
  logic [1:0]         m_d [SHAMT_W];
  logic [TAG_W-1:0]   t_q [SHAMT_W];
  logic [TAG_W-1:0]   t_d [SHAMT_W];

  // SRA keeps the MSB in place, so the original sign is always the current MSB.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                                   input logic en, input int k);
    int s;
    logic [WIDTH-1:0] sra;
    s = en ? 1 << k : 0;
    sra = $signed(d) >>> s;
    return m == 2'b00 ? d << s : m == 2'b01 ? d >> s : m == 2'b10 ? sra : (d >> s) | (d << (WIDTH - s));
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance || reset;
  assign out_valid = v_q[SHAMT_W-1];
  assign out_data  = d_q[SHAMT_W-1];
  assign out_tag   = t_q[SHAMT_W-1];

  // Remaining shamt is shifted down each stage so bit 0 is always the one to resolve.
  always_comb begin
    v_d[0] = in_valid;
    d_d[0] = shift_stage(in_data, in_mode, in_shamt[0], 0);
    s_d[0] = in_shamt >> 1;
    m_d[0] = in_mode;
    t_d[0] = in_tag;
    for (int k = 1; k < SHAMT_W; k++) begin
      v_d[k] = v_q[k-1];
      d_d[k] = shift_stage(d_q[k-1], m_q[k-1], s_q[k-1][0], k);
      s_d[k] = s_q[k-1] >> 1;
      m_d[k] = m_q[k-1];
      t_d[k] = t_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        s_q[k] <= '0;
        m_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        v_q[k] <= v_d[k];
        d_q[k] <= d_d[k];
        s_q[k] <= s_d[k];
        m_q[k] <= m_d[k];
        t_q[k] <= t_d[k];
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed and random checks of shift_unit_pipe against a scoreboard model.
module tb_shift_unit_pipe;
  logic        clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [31:0] in_data = 0, out_data;
  logic [4:0]  in_shamt = 0, in_tag = 0, out_tag;
  logic [1:0]  in_mode = 0;

  int checks = 0, errors = 0;

  typedef struct packed {logic [31:0] d; logic [4:0] t;} exp_t;
  exp_t        exp_q[$];
  bit          hist[$];
  logic        prev_stall = 0, was_reset = 0;
  logic [31:0] prev_d;
  logic [4:0]  prev_t;
  logic [31:0] b2b_exp[4] = '{32'h8000_0000, 32'h0F00_0000, 32'h8123_4567, 32'h0000_0000};

  always #5 clock = ~clock;

  shift_unit_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    logic [63:0] w;
    case (m)
      2'b00:   w = {32'b0, d} << s;
      2'b01:   w = {32'b0, d} >> s;
      2'b10:   w = {{32{d[31]}}, d} >> s;
      default: w = {d, d} >> s;
    endcase
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  // Timing model: out_valid mirrors whether a request was accepted SHAMT_W advancing edges ago.
  always @(negedge clock) begin
    exp_t e;
    chk("in_ready", in_ready, reset || !out_valid || out_ready);
    chk("out_valid", out_valid, hist[0]);
    if (prev_stall) begin
      chk("stall_data", out_data, prev_d);
      chk("stall_tag", out_tag, prev_t);
    end
    if (was_reset) begin
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
    end
    if (reset) begin
      hist = '{0, 0, 0, 0, 0};
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got tag %0h required none", out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", out_tag, e.t);
        end
      end
      if (in_valid && in_ready) exp_q.push_back({ref_shift(in_data, in_shamt, in_mode), in_tag});
      if (in_ready) begin
        hist.push_back(in_valid);
        void'(hist.pop_front());
      end
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_d = out_data;
    prev_t = out_tag;
    was_reset = reset;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, input logic [4:0] t,
                      input int bound, output bit ok);
    in_valid = 1; in_data = d; in_shamt = s; in_mode = m; in_tag = t;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      #1;
      ok = in_ready;
      cyc();
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(name, out_valid, 1);
  endtask

  initial begin
    bit ok;
    int lat, nacc, got, seen;
    logic [31:0] held;
    hist = '{0, 0, 0, 0, 0};
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);

    chk("model_sra", ref_shift(32'h8000_1234, 16, 2'b10), 32'hFFFF_8000);
    chk("model_ror", ref_shift(32'h1234_5678, 4, 2'b11), 32'h8123_4567);
    chk("model_sll", ref_shift(32'h0000_0001, 31, 2'b00), 32'h8000_0000);
    chk("model_sra_pos", ref_shift(32'h7FFF_FFFF, 31, 2'b10), 32'h0);

    send(32'h8000_1234, 16, 2'b10, 3, 10, ok);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("sra_latency", lat, 5);
    chk("sra_data", out_data, 32'hFFFF_8000);
    chk("sra_tag", out_tag, 3);
    cyc();

    send(32'h0000_0001, 31, 2'b00, 1, 10, ok);
    send(32'hF000_0000, 4, 2'b01, 2, 10, ok);
    send(32'h1234_5678, 4, 2'b11, 3, 10, ok);
    send(32'h7FFF_FFFF, 31, 2'b10, 4, 10, ok);
    in_valid = 0;
    wait_valid("b2b_arrive");
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", out_data, b2b_exp[i]);
      cyc();
    end

    for (int m = 0; m < 4; m++) send(32'hDEAD_BEEF, 0, 2'(m), 5'(m), 10, ok);
    in_valid = 0;
    wait_valid("zero_arrive");
    for (int i = 0; i < 4; i++) begin
      chk("zero_valid", out_valid, 1);
      chk("zero_data", out_data, 32'hDEAD_BEEF);
      cyc();
    end
    repeat (3) cyc();

    out_ready = 0;
    nacc = 0;
    for (int t = 1; t <= 7; t++) begin
      send(32'h0101_0101 * t, 5'(t), 2'(t), 5'(t), 3, ok);
      nacc += int'(ok);
    end
    in_valid = 0;
    chk("bp_accepts", nacc, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head_tag", out_tag, 1);
    chk("bp_head_data", out_data, 32'h0080_8080);
    held = out_data;
    repeat (4) cyc();
    chk("bp_hold", out_data, held);
    out_ready = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        chk("bp_order", out_tag, got + 1);
        got++;
      end
      cyc();
    end
    chk("bp_count", got, 5);

    for (int t = 1; t <= 3; t++) send(32'h1111_1111 * t, 5'(t), 2'b00, 5'(t), 10, ok);
    reset = 1;
    in_valid = 1; in_data = 32'hFFFF_FFFF; in_tag = 9;
    #1 chk("rst_in_ready_during", in_ready, 1);
    cyc();
    reset = 0;
    in_valid = 0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    seen = 0;
    repeat (10) begin
      seen += int'(out_valid);
      cyc();
    end
    chk("rst_no_stale", seen, 0);
    send(32'h1, 1, 2'b00, 4, 10, ok);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("post_rst_latency", lat, 5);
    chk("post_rst_data", out_data, 32'h2);
    chk("post_rst_tag", out_tag, 4);
    cyc();

    repeat (10000) begin
      in_valid  = $urandom_range(0, 9) < 7;
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = $urandom_range(0, 9) < 7;
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) cyc();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
